uart_tx_arbiter: RTL

Round-robin scheduler that shares the single UART transmitter driving ftdi_tx among NUM_REQ byte producers (echo path, status reporter, debug dumper, ...). It accepts one byte per grant over a valid/ready handshake, pulses the transmitter's data-valid, and waits for frame completion. It enforces an optional inter-frame gap and recovers via watchdog if the transmitter never reports done. Sits in top between the producers and the UART TX instance.

---
 rtl/uart_pkg.sv | 10 +
 rtl/rr_pick.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 82 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared widths, frame timing and arbiter FSM states for the UART TX path
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 104;
  localparam int FRAME_BITS = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_DONE, ST_GAP} state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first valid requester at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] index
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  always_comb begin
    index = '0;
    j = '0;
    // scan from farthest to nearest so the slot closest to ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req_valid[j]) index = j;
    end
  end
  assign any = |req_valid;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT_CYCLES = 2 * FRAME_BITS * DEFAULT_CLKS_PER_BIT
) (
  input  logic                       hwclk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_dv,
  output logic [BYTE_W-1:0]          tx_byte,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max2(max2(TIMEOUT_CYCLES, GAP_CYCLES), 1) + 1);
  state_t state;
  logic [IW-1:0] ptr, pick;
  logic any;
  logic [CW-1:0] cnt;
  logic [BYTE_W-1:0] bytes [NUM_REQ];
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_valid(req_valid),
    .ptr(ptr),
    .any(any),
    .index(pick)
  );
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) bytes[i] = req_data[i*BYTE_W +: BYTE_W];
  end
  assign busy = state != ST_IDLE;
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      req_ready <= '0;
      tx_dv <= 1'b0;
      tx_byte <= '0;
      grant_id <= '0;
      err_timeout <= 1'b0;
      cnt <= '0;
    end else begin
      req_ready <= '0;
      tx_dv <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        // a frame still on the wire (after reset or abort) blocks new grants
        ST_IDLE: if (any && !tx_active) begin
          tx_byte <= bytes[pick];
          grant_id <= pick;
          req_ready[pick] <= 1'b1;
          ptr <= int'(pick) == NUM_REQ - 1 ? '0 : pick + 1'b1;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          tx_dv <= 1'b1;
          cnt <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (tx_done) begin
          cnt <= '0;
          state <= GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (int'(cnt) == TIMEOUT_CYCLES - 1) begin
            err_timeout <= 1'b1;
            state <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        ST_GAP: if (int'(cnt) >= GAP_CYCLES - 1) state <= ST_IDLE;
          else cnt <= cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
